sprite_anim_renderer: RTL

Parametrised animated-sprite pixel generator for the VGA pipeline. Given the current scan position, it places a multi-frame sprite sheet at a programmable screen position with integer scaling and optional horizontal mirroring. It steps through animation frames on vertical-blank boundaries under a play/loop state machine. It drives an external synchronous sprite ROM and emits a palette index plus an opaque flag to the downstream palette/compositor stage.

---
 rtl/sprite_anim_renderer_if.sv | 12 +
 rtl/sprite_anim_renderer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_renderer_if.sv
// Sprite ROM port: the renderer issues a registered address and the ROM returns
// the palette index on the following rising edge.
interface sprite_anim_renderer_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned IDX_W  = 4
);
    logic [ADDR_W-1:0] rom_address;
    logic [IDX_W-1:0]  rom_q;

    modport master (output rom_address, input rom_q);
    modport slave  (input rom_address, output rom_q);
endinterface

// File: rtl/sprite_anim_renderer.sv
// Animated sprite pixel generator: hit test, ROM addressing with scale/mirror,
// play/loop frame sequencer and a 2-cycle registered pixel pipeline.
module sprite_anim_renderer #(
    parameter int unsigned SPRITE_W        = 70,
    parameter int unsigned SPRITE_H        = 120,
    parameter int unsigned NUM_FRAMES      = 4,
    parameter int unsigned SCALE           = 0,
    parameter int unsigned FRAME_HOLD      = 6,
    parameter int unsigned IDX_W           = 4,
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned TRANSPARENT_IDX = 0,
    parameter int unsigned ACTIVE_H        = 480,
    localparam int unsigned FRAME_W        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                   vga_clk,
    input  logic                   Reset,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic                   blank,
    input  logic [9:0]             sprite_x,
    input  logic [9:0]             sprite_y,
    input  logic                   mirror,
    input  logic                   play,
    input  logic                   stop,
    input  logic                   loop,
    sprite_anim_renderer_if.master rom,
    output logic [IDX_W-1:0]       pixel_idx,
    output logic                   pixel_opaque,
    output logic [FRAME_W-1:0]     anim_frame,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned SPAN_X   = SPRITE_W << SCALE;
    localparam int unsigned SPAN_Y   = SPRITE_H << SCALE;
    localparam int unsigned FRAME_SZ = SPRITE_W * SPRITE_H;
    localparam int unsigned HOLD_W   = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(FRAME_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        HOLD_LAST
    } state_t;

    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [9:0]          shadow_x;
    logic [9:0]          shadow_y;
    logic                shadow_mirror;
    logic                hit_d1;
    logic                blank_d1;
    logic                hit_d2;
    logic                blank_d2;

    logic                frame_tick_c;
    logic [10:0]         dx_c;
    logic [10:0]         dy_c;
    logic                hit_c;
    logic [9:0]          col_c;
    logic [9:0]          row_c;
    logic [ADDR_W-1:0]   addr_c;
    logic [FRAME_W-1:0]  next_frame_c;

    // Bit 10 of the differences is the sign: left of / above the sprite never hits.
    always_comb begin
        frame_tick_c = (DrawX == 10'd0) && (DrawY == 10'(ACTIVE_H));
        dx_c         = {1'b0, DrawX} - {1'b0, shadow_x};
        dy_c         = {1'b0, DrawY} - {1'b0, shadow_y};
        hit_c        = !dx_c[10] && !dy_c[10]
                       && (32'(dx_c[9:0]) < SPAN_X) && (32'(dy_c[9:0]) < SPAN_Y);
        col_c        = dx_c[9:0] >> SCALE;
        row_c        = dy_c[9:0] >> SCALE;
        if (shadow_mirror) begin
            col_c = 10'(SPRITE_W - 1) - col_c;
        end
        addr_c       = ADDR_W'(32'(anim_frame) * FRAME_SZ + 32'(row_c) * SPRITE_W + 32'(col_c));
        next_frame_c = anim_frame + FRAME_W'(1);
    end

    // Pixel pipeline: address/hit at edge n, ROM data at n+1, output at n+2.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            hit_d1          <= 1'b0;
            blank_d1        <= 1'b0;
            hit_d2          <= 1'b0;
            blank_d2        <= 1'b0;
            rom.rom_address <= '0;
            pixel_idx       <= '0;
            pixel_opaque    <= 1'b0;
        end else begin
            hit_d1   <= hit_c;
            blank_d1 <= blank;
            hit_d2   <= hit_d1;
            blank_d2 <= blank_d1;
            if (hit_c) begin
                rom.rom_address <= addr_c;
            end
            if (hit_d2 && blank_d2 && (rom.rom_q != IDX_W'(TRANSPARENT_IDX))) begin
                pixel_opaque <= 1'b1;
                pixel_idx    <= rom.rom_q;
            end else begin
                pixel_opaque <= 1'b0;
                pixel_idx    <= '0;
            end
        end
    end

    // Shadow position registers and the play/loop animation sequencer.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            anim_frame    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            shadow_x      <= '0;
            shadow_y      <= '0;
            shadow_mirror <= 1'b0;
        end else begin
            done <= 1'b0;
            if (frame_tick_c) begin
                shadow_x      <= sprite_x;
                shadow_y      <= sprite_y;
                shadow_mirror <= mirror;
            end
            if (stop) begin
                state      <= IDLE;
                hold_cnt   <= '0;
                anim_frame <= '0;
                busy       <= 1'b0;
            end else if (play) begin
                state      <= PLAY;
                hold_cnt   <= '0;
                anim_frame <= '0;
                busy       <= 1'b1;
            end else if ((state == PLAY) && frame_tick_c) begin
                if (hold_cnt == HOLD_MAX) begin
                    hold_cnt <= '0;
                    if (anim_frame == LAST_FRAME) begin
                        if (loop) begin
                            anim_frame <= '0;
                        end else begin
                            state <= HOLD_LAST;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        anim_frame <= next_frame_c;
                        // Entering the last frame of a one-shot run ends playback here.
                        if ((next_frame_c == LAST_FRAME) && !loop) begin
                            state <= HOLD_LAST;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end else begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
            end
        end
    end

endmodule
